// File: rtl/fakeram_1r1w_param.sv
// Behavioural 1R1W SRAM model: per-bit write mask, 1- or 2-cycle read latency,
// selectable read-during-write result, and a zeroing sweep after reset.
// Optional define FAKERAM_X_CORRUPT_EN turns X on enables/addresses into array/read corruption.
module fakeram_1r1w_param #(
    parameter int BITS          = 64,
    parameter int WORD_DEPTH    = 64,
    parameter int ADDR_WIDTH    = 6,
    parameter int RD_LATENCY    = 1,
    parameter int RDW_MODE      = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic                  rd_ce_in,
    input  logic [ADDR_WIDTH-1:0] rd_addr_in,
    output logic [BITS-1:0]       rd_out,
    output logic                  rd_valid_out,
    input  logic                  wr_ce_in,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [BITS-1:0]       wd_in,
    input  logic [BITS-1:0]       w_mask_in,
    output logic                  init_done_out,
    output logic                  dbg_state
);

    // Handshake: reads and writes are accepted on every clock while init_done_out
    // is high (no backpressure); rd_valid_out is high for exactly one cycle per
    // accepted read, RD_LATENCY edges after it, and rd_out holds between reads.

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(WORD_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WORD_DEPTH - 1);

    logic [BITS-1:0]       mem [0:WORD_DEPTH-1];

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;

    logic                  rd_in_range;
    logic                  wr_in_range;
    logic                  rd_req;
    logic                  rd_valid_word;
    logic [BITS-1:0]       rd_word;
    logic [BITS-1:0]       wr_old;
    logic [BITS-1:0]       wr_merged;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BITS-1:0]       mem_wdata;

    logic                  s1_valid;
    logic [BITS-1:0]       s1_data;

`ifdef FAKERAM_X_CORRUPT_EN
    logic                  wr_x;
    logic                  rd_x;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_INIT: begin
                cnt_nxt = cnt + ADDR_WIDTH'(1);
                if (cnt == LAST_IDX) begin
                    state_nxt = ST_READY;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_in_range = ({1'b0, rd_addr_in} < DEPTH_W);
        wr_in_range = ({1'b0, wr_addr_in} < DEPTH_W);

        wr_old = '0;
        if (wr_in_range) begin
            wr_old = mem[wr_addr_in];
        end
        wr_merged = (wd_in & w_mask_in) | (wr_old & ~w_mask_in);

        // Out-of-range reads and the RDW_MODE=2 collision both return all-X.
        rd_word = 'x;
        if (rd_in_range) begin
            rd_word = mem[rd_addr_in];
            if (wr_ce_in && wr_in_range && (rd_addr_in == wr_addr_in)) begin
                if (RDW_MODE == 1) begin
                    rd_word = wr_merged;
                end else if (RDW_MODE == 2) begin
                    rd_word = 'x;
                end
            end
        end

        rd_req        = 1'b0;
        rd_valid_word = 1'b1;
        mem_we        = 1'b0;
        mem_addr      = wr_addr_in;
        mem_wdata     = wr_merged;
        if (!reset_in) begin
            if (state == ST_INIT) begin
                mem_we    = 1'b1;
                mem_addr  = cnt;
                mem_wdata = '0;
            end else begin
                mem_we = wr_ce_in && wr_in_range;
                rd_req = rd_ce_in;
            end
        end

`ifdef FAKERAM_X_CORRUPT_EN
        wr_x = 1'b0;
        rd_x = 1'b0;
        if (!reset_in && (state == ST_READY)) begin
            wr_x = $isunknown(wr_ce_in) || ((wr_ce_in === 1'b1) && $isunknown(wr_addr_in));
            rd_x = $isunknown(rd_ce_in) || ((rd_ce_in === 1'b1) && $isunknown(rd_addr_in));
        end
        if (wr_x) begin
            mem_we = 1'b0;
        end
        if (rd_x) begin
            rd_req        = 1'b1;
            rd_word       = 'x;
            rd_valid_word = 1'bx;
        end
`endif
    end

    // Array storage has no reset: contents only change through the sweep or writes.
    always_ff @(posedge clk) begin
`ifdef FAKERAM_X_CORRUPT_EN
        if (wr_x) begin
            for (int i = 0; i < WORD_DEPTH; i++) begin
                mem[i] <= 'x;
            end
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (wr_x) begin
            $warning("fakeram_1r1w_param: X on wr_ce_in/wr_addr_in, array corrupted");
        end
        if (rd_x) begin
            $warning("fakeram_1r1w_param: X on rd_ce_in/rd_addr_in, read data corrupted");
        end
`else
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state    <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (rd_req) begin
                s1_valid <= rd_valid_word;
                s1_data  <= rd_word;
            end else begin
                s1_valid <= 1'b0;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic            s2_valid;
            logic [BITS-1:0] s2_data;

            // Data only moves on a real read so rd_out holds through idle cycles.
            always_ff @(posedge clk) begin
                if (reset_in) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rd_out       = s2_data;
            assign rd_valid_out = s2_valid;
        end else begin : g_lat1
            assign rd_out       = s1_data;
            assign rd_valid_out = s1_valid;
        end
    endgenerate

    assign init_done_out = (state == ST_READY);
    assign dbg_state     = state;

endmodule

// File: tb/tb_fakeram_1r1w_param.sv
// Bench for fakeram_1r1w_param: five configurations share one stimulus stream and
// are checked every cycle against a latency-queue model, plus literal spot checks.
module tb_fakeram_1r1w_param;

    localparam int NI    = 5;
    localparam int DEPTH = 48;
    // dut0: L1/old  dut1: L1/new  dut2: L1/X  dut3: L2/old  dut4: L2/new, no sweep
    localparam logic [NI-1:0]   LAT2_V = 5'b11000;
    localparam logic [NI-1:0]   INIT_V = 5'b01111;
    localparam logic [2*NI-1:0] RDW_V  = {2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset_in;
    logic        rd_ce_in;
    logic [5:0]  rd_addr_in;
    logic        wr_ce_in;
    logic [5:0]  wr_addr_in;
    logic [15:0] wd_in;
    logic [15:0] w_mask_in;

    logic [15:0] rd_out_a    [NI];
    logic        rd_valid_a  [NI];
    logic        init_done_a [NI];
    logic        dbg_a       [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        fakeram_1r1w_param #(
            .BITS         (16),
            .WORD_DEPTH   (DEPTH),
            .ADDR_WIDTH   (6),
            .RD_LATENCY   (LAT2_V[g] ? 2 : 1),
            .RDW_MODE     (int'(RDW_V[2*g +: 2])),
            .INIT_ON_RESET(int'(INIT_V[g]))
        ) u_dut (
            .clk          (clk),
            .reset_in     (reset_in),
            .rd_ce_in     (rd_ce_in),
            .rd_addr_in   (rd_addr_in),
            .rd_out       (rd_out_a[g]),
            .rd_valid_out (rd_valid_a[g]),
            .wr_ce_in     (wr_ce_in),
            .wr_addr_in   (wr_addr_in),
            .wd_in        (wd_in),
            .w_mask_in    (w_mask_in),
            .init_done_out(init_done_a[g]),
            .dbg_state    (dbg_a[g])
        );
    end

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int inst, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d got %h expected %h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    typedef struct {
        int          inst;
        int          due;
        logic [15:0] d;
        bit          k;
    } pend_t;

    pend_t       exp_q [$];
    logic [15:0] mem_m   [NI][DEPTH];
    bit          known_m [NI][DEPTH];
    int          sweep_pos [NI];
    bit          exp_init  [NI];
    bit          exp_valid [NI];
    bit          exp_k     [NI];
    logic [15:0] exp_out   [NI];
    int          edge_n = 0;

    // A read accepted at edge n becomes visible after edge n+latency-1.
    always @(posedge clk) begin
        int          ra;
        int          wa;
        int          lat;
        int          mode;
        logic [15:0] d;
        logic [15:0] merged;
        bit          k;
        bit          rdy;
        edge_n++;
        ra = int'(rd_addr_in);
        wa = int'(wr_addr_in);
        if (reset_in) begin
            exp_q.delete();
            for (int i = 0; i < NI; i++) begin
                sweep_pos[i] = 0;
                exp_init[i]  = !INIT_V[i];
                exp_valid[i] = 1'b0;
                exp_out[i]   = '0;
                exp_k[i]     = 1'b1;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                lat  = LAT2_V[i] ? 2 : 1;
                mode = int'(RDW_V[2*i +: 2]);
                rdy  = INIT_V[i] ? (sweep_pos[i] == DEPTH) : 1'b1;
                if (!rdy) begin
                    mem_m[i][sweep_pos[i]]   = '0;
                    known_m[i][sweep_pos[i]] = 1'b1;
                    sweep_pos[i]++;
                end else begin
                    merged = '0;
                    if (wa < DEPTH) begin
                        merged = (wd_in & w_mask_in) | (mem_m[i][wa] & ~w_mask_in);
                    end
                    if (rd_ce_in) begin
                        d = '0;
                        k = 1'b0;
                        if (ra < DEPTH) begin
                            d = mem_m[i][ra];
                            k = known_m[i][ra];
                            if (wr_ce_in && (wa == ra)) begin
                                if (mode == 1) begin
                                    d = merged;
                                    k = known_m[i][ra] || (w_mask_in == 16'hFFFF);
                                end else if (mode == 2) begin
                                    k = 1'b0;
                                end
                            end
                        end
                        exp_q.push_back('{i, edge_n + lat - 1, d, k});
                    end
                    if (wr_ce_in && (wa < DEPTH)) begin
                        known_m[i][wa] = known_m[i][wa] || (w_mask_in == 16'hFFFF);
                        mem_m[i][wa]   = merged;
                    end
                end
                exp_init[i]  = INIT_V[i] ? (sweep_pos[i] == DEPTH) : 1'b1;
                exp_valid[i] = 1'b0;
                for (int j = exp_q.size() - 1; j >= 0; j--) begin
                    if ((exp_q[j].inst == i) && (exp_q[j].due == edge_n)) begin
                        exp_valid[i] = 1'b1;
                        exp_out[i]   = exp_q[j].d;
                        exp_k[i]     = exp_q[j].k;
                        exp_q.delete(j);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (edge_n > 0) begin
            for (int i = 0; i < NI; i++) begin
                chk("init_done", i, 16'(init_done_a[i]), 16'(exp_init[i]));
                chk("dbg_state", i, 16'(dbg_a[i]), 16'(exp_init[i]));
                chk("rd_valid", i, 16'(rd_valid_a[i]), 16'(exp_valid[i]));
                if (exp_k[i]) begin
                    chk("rd_out", i, rd_out_a[i], exp_out[i]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit rce, input int ra, input bit wce, input int wa,
                       input logic [15:0] wd, input logic [15:0] wm);
        rd_ce_in   = rce;
        rd_addr_in = 6'(ra);
        wr_ce_in   = wce;
        wr_addr_in = 6'(wa);
        wd_in      = wd;
        w_mask_in  = wm;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 0, 1'b0, 0, 16'h0, 16'h0);
    endtask

    task automatic wr(input int a, input logic [15:0] d, input logic [15:0] m);
        cyc(1'b0, 0, 1'b1, a, d, m);
    endtask

    task automatic rd(input int a);
        cyc(1'b1, a, 1'b0, 0, 16'h0, 16'h0);
    endtask

    // Counts cycles from reset release until dut0 reports ready, bounded.
    task automatic wait_init(input string nm);
        int n;
        n = 0;
        while (!init_done_a[0] && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 0, 16'(n), 16'd48);
    endtask

    typedef struct {
        bit          rce;
        int          ra;
        bit          wce;
        int          wa;
        logic [15:0] wd;
        logic [15:0] wm;
        bit          lit_en;
        logic [15:0] lit0;
        logic [15:0] lit1;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 20, 1'b1, 21, 16'h1234, 16'hFFFF, 1'b1, 16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 21, 1'b1, 20, 16'hABCD, 16'h00FF, 1'b1, 16'h1234, 16'h1234};
        vecs[2] = '{1'b1, 20, 1'b1, 20, 16'h5500, 16'hFF00, 1'b1, 16'h00CD, 16'h55CD};
        vecs[3] = '{1'b1, 47, 1'b1, 47, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'hFFFF};
        vecs[4] = '{1'b1, 0,  1'b1, 63, 16'h0F0F, 16'hFFFF, 1'b1, 16'h0000, 16'h0000};
        vecs[5] = '{1'b1, 47, 1'b0, 0,  16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF};
        vecs[6] = '{1'b1, 63, 1'b0, 0,  16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[7] = '{1'b1, 20, 1'b0, 0,  16'h0000, 16'h0000, 1'b1, 16'h55CD, 16'h55CD};

        reset_in = 1'b1;
        rd_ce_in = 1'b0; rd_addr_in = '0;
        wr_ce_in = 1'b0; wr_addr_in = '0;
        wd_in = '0; w_mask_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_rd_out", 0, rd_out_a[0], 16'h0000);
        chk("reset_init_done_noinit", 4, 16'(init_done_a[4]), 16'd1);
        reset_in = 1'b0;
        wait_init("init_cycles");

        for (int a = 0; a < DEPTH; a++) begin
            rd(a);
        end
        chk("sweep_last_word", 0, rd_out_a[0], 16'h0000);

        // masked write merge
        wr(5, 16'hA5A5, 16'hFFFF);
        wr(5, 16'h3C00, 16'hFF00);
        rd(5);
        chk("masked_read", 0, rd_out_a[0], 16'h3CA5);
        chk("masked_valid", 0, 16'(rd_valid_a[0]), 16'd1);
        idle();
        chk("idle_valid", 0, 16'(rd_valid_a[0]), 16'd0);
        chk("idle_hold", 0, rd_out_a[0], 16'h3CA5);

        // read-during-write on the same address
        wr(7, 16'h1111, 16'hFFFF);
        cyc(1'b1, 7, 1'b1, 7, 16'h2222, 16'hFFFF);
        chk("rdw_old", 0, rd_out_a[0], 16'h1111);
        chk("rdw_new", 1, rd_out_a[1], 16'h2222);
        chk("rdw_x_valid", 2, 16'(rd_valid_a[2]), 16'd1);
        idle();
        chk("rdw_old_lat2", 3, rd_out_a[3], 16'h1111);
        rd(7);
        chk("rdw_follow", 0, rd_out_a[0], 16'h2222);
        chk("rdw_follow", 1, rd_out_a[1], 16'h2222);
        chk("rdw_follow", 2, rd_out_a[2], 16'h2222);

        // two-stage pipelining
        wr(1, 16'h0001, 16'hFFFF);
        wr(2, 16'h0002, 16'hFFFF);
        wr(3, 16'h0003, 16'hFFFF);
        idle();
        rd(1);
        chk("lat2_c1_valid", 3, 16'(rd_valid_a[3]), 16'd0);
        chk("lat1_c1_data", 0, rd_out_a[0], 16'h0001);
        rd(2);
        chk("lat2_c2_data", 3, rd_out_a[3], 16'h0001);
        chk("lat2_c2_valid", 3, 16'(rd_valid_a[3]), 16'd1);
        rd(3);
        chk("lat2_c3_data", 3, rd_out_a[3], 16'h0002);
        idle();
        chk("lat2_c4_data", 3, rd_out_a[3], 16'h0003);
        chk("lat2_c4_valid", 3, 16'(rd_valid_a[3]), 16'd1);
        idle();
        chk("lat2_c5_valid", 3, 16'(rd_valid_a[3]), 16'd0);
        chk("lat2_c5_hold", 3, rd_out_a[3], 16'h0003);

        // out-of-range
        wr(50, 16'hFFFF, 16'hFFFF);
        rd(50);
        chk("oor_valid", 0, 16'(rd_valid_a[0]), 16'd1);
        rd(2);
        chk("oor_no_alias", 0, rd_out_a[0], 16'h0002);

        // mixed back-to-back vectors
        foreach (vecs[v]) begin
            cyc(vecs[v].rce, vecs[v].ra, vecs[v].wce, vecs[v].wa, vecs[v].wd, vecs[v].wm);
            if (vecs[v].lit_en) begin
                chk("vec_old", 0, rd_out_a[0], vecs[v].lit0);
                chk("vec_new", 1, rd_out_a[1], vecs[v].lit1);
            end
        end

        // reset with a read in flight, then reset mid-sweep
        wr(10, 16'hBEEF, 16'hFFFF);
        rd(10);
        chk("pre_reset_read", 0, rd_out_a[0], 16'hBEEF);
        reset_in = 1'b1;
        rd_ce_in = 1'b0;
        @(negedge clk);
        chk("inflight_valid", 3, 16'(rd_valid_a[3]), 16'd0);
        chk("inflight_data", 3, rd_out_a[3], 16'h0000);
        chk("reset_data", 0, rd_out_a[0], 16'h0000);
        reset_in = 1'b0;
        repeat (20) @(negedge clk);
        reset_in = 1'b1;
        @(negedge clk);
        reset_in = 1'b0;
        wait_init("resweep_cycles");
        rd(10);
        chk("resweep_zeroed", 0, rd_out_a[0], 16'h0000);
        idle();
        chk("noinit_keeps", 4, rd_out_a[4], 16'hBEEF);
        chk("resweep_zeroed_lat2", 3, rd_out_a[3], 16'h0000);
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
